falafel_config_regfile: RTL and testbench
=========================================

// Module: falafel_config_regfile
// PURPOSE
//  Parametrised, double-buffered allocator configuration register file.
//  - Bus side: valid/ready request channel with byte strobes; one-entry response buffer with error flag.
//  - Writes land in SHADOW regs; ACTIVE regs (cfg_o) update atomically on a commit.
//  - Commit happens only while the allocator core reports idle, so free-list/lock pointers never change mid-operation.
// PARAMETERS
//  DATA_W     64     register/bus width in bits; multiple of 8
//  NUM_REGS   4      number of config registers (>=1); CTRL register sits at word index NUM_REGS
//  BASE_ADDR  'h0    byte address of word 0; must be DATA_W/8 aligned
//  RO_MASK    '0     NUM_REGS bits; bit i=1 -> reg i read-only from bus (reads return reset value 0)
// PORTS
//  clk_i        in   1               clock
//  rst_i        in   1               synchronous, active-high reset
//  req_valid_i  in   1               request valid
//  req_ready_o  out  1               request accepted when valid&&ready
//  req_write_i  in   1               1=write, 0=read
//  req_addr_i   in   DATA_W          byte address
//  req_wdata_i  in   DATA_W          write data
//  req_strb_i   in   DATA_W/8        byte write enables
//  rsp_valid_o  out  1               response valid
//  rsp_ready_i  in   1               response consumed when valid&&ready
//  rsp_rdata_o  out  DATA_W          read data (0 for writes/errors)
//  rsp_err_o    out  1               decode/permission error
//  core_idle_i  in   1               allocator FSM idle; commit permitted
//  cfg_o        out  NUM_REGS*DATA_W ACTIVE regs, reg i at [i*DATA_W +: DATA_W]
//  cfg_update_o out  1               1-cycle pulse the cycle after ACTIVE changes
// BEHAVIOUR
//  Reset
//   - shadow=active=0, pending=0, dirty=0, rsp_valid_o=0, cfg_update_o=0, req_ready_o=1 the cycle after reset.
//  Handshake
//   - req_ready_o = !rsp_valid_o || rsp_ready_i; one transaction outstanding.
//   - Response valid the cycle after acceptance (latency 1); held stable until rsp_ready_i.
//  Decode
//   - off = addr-BASE_ADDR; err if off misaligned (low log2(DATA_W/8) bits !=0) or off/(DATA_W/8) > NUM_REGS.
//   - Write to RO reg also errs. Any errored write has no side effect.
//  Shadow write
//   - Byte j updated iff strb[j]; strb==0 is a legal no-op write. Sets dirty.
//  Read
//   - Returns SHADOW value (pending contents), not ACTIVE.
//  CTRL (word NUM_REGS)
//   - Write with strb[0] && wdata[0] -> pending=1.
//   - Read = {.., dirty(bit1), pending(bit0)}; other bits 0.
//  Commit
//   - Cycle where pending && core_idle_i: active<=shadow(q), pending<=0, dirty<=0, next-cycle cfg_update_o=1.
//   - Pending waits indefinitely while core_idle_i=0.
//  Simultaneous events
//   - Shadow write in the commit cycle: active gets pre-write shadow; dirty stays 1.
//   - CTRL commit write in the commit cycle: pending stays 1 (re-armed).
//  Reset mid-transaction
//   - Drops any outstanding response and pending commit; no partial state survives.
// STRUCTURE
//  - falafel_pkg gains: CFG_CTRL_COMMIT_BIT=0, CFG_CTRL_DIRTY_BIT=1, typedef cfg_rsp_t {rdata, err}.
//  - One sub-module: falafel_cfg_rsp_buf, a 1-entry valid/ready holding register for cfg_rsp_t.
//  - Decode, shadow/active arrays and commit logic stay inline.
// TESTING (DATA_W=64, NUM_REGS=4, BASE_ADDR=0, RO_MASK=4'b1000)
//  1. Reset, read addr 0x08 -> rsp 1 cycle later: rdata=0, err=0; cfg_o=0; req_ready_o=1.
//  2. Write 0x08 data 0xDEAD_BEEF strb 0x0F; read 0x08 -> 0xDEAD_BEEF; cfg_o[127:64] still 0; CTRL read = 0x2.
//  3. core_idle_i=0, write CTRL=1 -> CTRL reads 0x3, cfg_o unchanged; raise core_idle_i -> next cycle cfg_o[127:64]=0xDEAD_BEEF, cfg_update_o pulses once, CTRL=0.
//  4. Write 0x18 (RO), 0x0C (misaligned), 0x28 (out of range) -> each err=1, rdata=0, shadow unchanged.
//  5. Hold rsp_ready_i=0 after a read: req_ready_o=0, rsp held stable for 5 cycles; release -> accepted same cycle.
//  6. Shadow write to 0x00 in the exact commit cycle -> active gets old value, CTRL reads dirty=1; assert rst_i with pending=1 -> pending=0, rsp_valid_o=0.

Source files
------------

// File: rtl/falafel_pkg.sv
// Shared definitions for the falafel allocator configuration block.
package falafel_pkg;

  localparam int unsigned CFG_DATA_W          = 64;
  localparam int unsigned CFG_CTRL_COMMIT_BIT = 0;
  localparam int unsigned CFG_CTRL_DIRTY_BIT  = 1;

  // Reference response layout; the register file re-declares it at its own DATA_W.
  typedef struct packed {
    logic [CFG_DATA_W-1:0] rdata;
    logic                  err;
  } cfg_rsp_t;

endpackage

// File: rtl/falafel_cfg_rsp_buf.sv
// One-entry valid/ready holding register for configuration bus responses.
module falafel_cfg_rsp_buf #(
  parameter type rsp_t = falafel_pkg::cfg_rsp_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  rsp_t in_data,
  output logic out_valid,
  input  logic out_ready,
  output rsp_t out_data
);

  // A new response may enter in the same cycle the held one drains.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/falafel_config_regfile.sv
// Double-buffered allocator configuration register file: bus writes land in
// shadow registers, which are copied to the active set only while the core is idle.
module falafel_config_regfile
  import falafel_pkg::*;
#(
  parameter int unsigned         DATA_W    = 64,
  parameter int unsigned         NUM_REGS  = 4,
  parameter logic [DATA_W-1:0]   BASE_ADDR = '0,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_write_i,
  input  logic [DATA_W-1:0]          req_addr_i,
  input  logic [DATA_W-1:0]          req_wdata_i,
  input  logic [DATA_W/8-1:0]        req_strb_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  input  logic                       core_idle_i,
  output logic [NUM_REGS*DATA_W-1:0] cfg_o,
  output logic                       cfg_update_o
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned OFF_LSB = $clog2(STRB_W);

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  logic [DATA_W-1:0]   shadow_q [NUM_REGS];
  logic [DATA_W-1:0]   active_q [NUM_REGS];
  logic                pending_q;
  logic                dirty_q;
  logic                update_q;

  logic                accept;
  logic                commit;
  logic [DATA_W-1:0]   off;
  logic [DATA_W-1:0]   word;
  logic                misaligned;
  logic                out_of_range;
  logic                is_ctrl;
  logic                is_ro;
  logic                dec_err;
  logic [NUM_REGS-1:0] reg_sel;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   ctrl_word;
  logic                shadow_we;
  logic                ctrl_arm;
  rsp_t                rsp_d;
  rsp_t                rsp_q;

  assign accept = req_valid_i && req_ready_o;
  assign commit = pending_q && core_idle_i;

  // Address decode, permission check and read mux.
  always_comb begin
    off          = req_addr_i - BASE_ADDR;
    word         = off >> OFF_LSB;
    misaligned   = (off & DATA_W'(STRB_W - 1)) != '0;
    out_of_range = word > DATA_W'(NUM_REGS);
    is_ctrl      = word == DATA_W'(NUM_REGS);
    reg_sel      = '0;
    is_ro        = 1'b0;
    rd_word      = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (word == DATA_W'(i)) begin
        reg_sel[i] = 1'b1;
        is_ro      = RO_MASK[i];
        rd_word    = RO_MASK[i] ? '0 : shadow_q[i];
      end
    end
    ctrl_word                      = '0;
    ctrl_word[CFG_CTRL_DIRTY_BIT]  = dirty_q;
    ctrl_word[CFG_CTRL_COMMIT_BIT] = pending_q;

    dec_err   = misaligned || out_of_range || (req_write_i && is_ro);
    shadow_we = accept && req_write_i && !dec_err && !is_ctrl;
    ctrl_arm  = accept && req_write_i && !dec_err && is_ctrl &&
                req_strb_i[0] && req_wdata_i[CFG_CTRL_COMMIT_BIT];

    rsp_d     = '0;
    rsp_d.err = dec_err;
    if (!req_write_i && !dec_err) begin
      rsp_d.rdata = is_ctrl ? ctrl_word : rd_word;
    end
  end

  // Shadow/active arrays and commit; active copies the pre-write shadow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pending_q <= 1'b0;
      dirty_q   <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      update_q  <= commit;
      pending_q <= ctrl_arm || (pending_q && !commit);
      dirty_q   <= shadow_we || (dirty_q && !commit);
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (commit) begin
          active_q[i] <= shadow_q[i];
        end
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (shadow_we && reg_sel[i] && req_strb_i[b]) begin
            shadow_q[i][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
          end
        end
      end
    end
  end

  falafel_cfg_rsp_buf #(
    .rsp_t (rsp_t)
  ) u_rsp_buf (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_valid  (req_valid_i),
    .in_ready  (req_ready_o),
    .in_data   (rsp_d),
    .out_valid (rsp_valid_o),
    .out_ready (rsp_ready_i),
    .out_data  (rsp_q)
  );

  assign rsp_rdata_o  = rsp_q.rdata;
  assign rsp_err_o    = rsp_q.err;
  assign cfg_update_o = update_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign cfg_o[g*DATA_W +: DATA_W] = active_q[g];
  end

endmodule

// File: tb/tb_falafel_config_regfile.sv
// Scoreboard bench for falafel_config_regfile with an array-based reference model.
module tb_falafel_config_regfile;

  localparam int unsigned DW = 64;
  localparam int unsigned NR = 4;
  localparam logic [NR-1:0] RO = 4'b1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [DW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [7:0]    req_strb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          core_idle = 1'b1;
  logic [NR*DW-1:0] cfg;
  logic          cfg_update;

  int checks = 0;
  int errors = 0;
  int last_wait = 0;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];

  falafel_config_regfile #(
    .DATA_W    (DW),
    .NUM_REGS  (NR),
    .BASE_ADDR (64'h0),
    .RO_MASK   (RO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_strb_i   (req_strb),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .core_idle_i  (core_idle),
    .cfg_o        (cfg),
    .cfg_update_o (cfg_update)
  );

  always #5 clk = ~clk;

  // Reference model state: values that hold after the most recent clock edge.
  logic [DW-1:0] m_sh [NR];
  logic [DW-1:0] m_act [NR];
  logic m_pend = 1'b0, m_dirty = 1'b0, m_upd = 1'b0, m_rv = 1'b0;
  logic [3:0] ro_v = RO;

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
  end

  // Model: compare architectural outputs, then advance by one edge.
  always @(negedge clk) begin
    logic          m_ready, acc, cmt, bad, nx_pend, nx_dirty;
    logic [DW-1:0] off, idx, exp_word;
    logic [NR*DW-1:0] exp_cfg;
    exp_t          ex;
    int            ix;

    m_ready = !m_rv || rsp_ready;
    for (int i = 0; i < NR; i++) exp_cfg[i*DW +: DW] = m_act[i];
    checks++;
    if (req_ready !== m_ready) begin
      errors++;
      $display("FAIL req_ready: got %b expected %b at %0t", req_ready, m_ready, $time);
    end
    checks++;
    if (cfg !== exp_cfg) begin
      errors++;
      $display("FAIL cfg_o: got %h expected %h at %0t", cfg, exp_cfg, $time);
    end
    checks++;
    if (cfg_update !== m_upd) begin
      errors++;
      $display("FAIL cfg_update: got %b expected %b at %0t", cfg_update, m_upd, $time);
    end

    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_sh[i]  = '0;
        m_act[i] = '0;
      end
      m_pend = 1'b0; m_dirty = 1'b0; m_upd = 1'b0; m_rv = 1'b0;
      sb.delete();
    end else begin
      acc      = req_valid && m_ready;
      cmt      = m_pend && core_idle;
      nx_pend  = cmt ? 1'b0 : m_pend;
      nx_dirty = cmt ? 1'b0 : m_dirty;
      if (cmt) for (int i = 0; i < NR; i++) m_act[i] = m_sh[i];
      if (acc) begin
        off = req_addr;
        idx = off / 8;
        ix  = (idx < 4) ? int'(idx) : 0;
        bad = (off % 8 != 0) || (idx > NR) || (req_write && idx < NR && ro_v[ix]);
        ex.err   = bad;
        ex.rdata = '0;
        if (!bad && !req_write) begin
          if (idx == NR) exp_word = {62'b0, m_dirty, m_pend};
          else           exp_word = ro_v[ix] ? '0 : m_sh[ix];
          ex.rdata = exp_word;
        end
        if (!bad && req_write) begin
          if (idx == NR) begin
            if (req_strb[0] && req_wdata[0]) nx_pend = 1'b1;
          end else begin
            for (int b = 0; b < 8; b++)
              if (req_strb[b]) m_sh[ix][b*8 +: 8] = req_wdata[b*8 +: 8];
            nx_dirty = 1'b1;
          end
        end
        sb.push_back(ex);
      end
      m_pend  = nx_pend;
      m_dirty = nx_dirty;
      m_upd   = cmt;
      m_rv    = acc ? 1'b1 : (rsp_ready ? 1'b0 : m_rv);
    end
  end

  // Monitor: pops the scoreboard on every consumed response and checks stability while stalled.
  logic held = 1'b0;
  exp_t held_v;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== held_v.rdata || rsp_err !== held_v.err) begin
          errors++;
          $display("FAIL rsp_hold: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                   rsp_valid, rsp_rdata, rsp_err, held_v.rdata, held_v.err);
        end
      end
      if (rsp_valid && rsp_ready) begin
        held = 1'b0;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got d=%h e=%b expected no response", rsp_rdata, rsp_err);
        end else begin
          e = sb.pop_front();
          if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            errors++;
            $display("FAIL rsp_data: got d=%h e=%b expected d=%h e=%b at %0t",
                     rsp_rdata, rsp_err, e.rdata, e.err, $time);
          end
        end
      end else if (rsp_valid === 1'b1) begin
        held = 1'b1;
        held_v.rdata = rsp_rdata;
        held_v.err   = rsp_err;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called and returns just after a rising edge; unblocks a stalled response if needed.
  task automatic issue(input logic wr, input logic [DW-1:0] a, input logic [DW-1:0] d,
                       input logic [7:0] s);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_strb = s;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      n++;
      @(negedge clk);
    end
    last_wait = n;
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got ready=%b expected 1 within 50 cycles", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] a;
    tick(3);
    rst = 1'b0;
    chk("ready_after_reset", {63'b0, req_ready}, 64'd1);
    chk("cfg_after_reset", {63'b0, |cfg}, 64'd0);
    chk("rsp_valid_after_reset", {63'b0, rsp_valid}, 64'd0);

    // Basic read, partial write, shadow readback, CTRL dirty
    issue(1'b0, 64'h08, '0, 8'h00);
    issue(1'b1, 64'h08, 64'hDEAD_BEEF, 8'h0F);
    issue(1'b0, 64'h08, '0, 8'h00);
    issue(1'b0, 64'h20, '0, 8'h00);
    chk("cfg1_before_commit", cfg[127:64], 64'h0);

    // Commit deferred until the core is idle
    core_idle = 1'b0;
    issue(1'b1, 64'h20, 64'h1, 8'h01);
    issue(1'b0, 64'h20, '0, 8'h00);
    tick(3);
    chk("cfg1_while_busy", cfg[127:64], 64'h0);
    core_idle = 1'b1;
    tick(1);
    chk("cfg1_after_commit", cfg[127:64], 64'hDEAD_BEEF);
    chk("update_pulse", {63'b0, cfg_update}, 64'd1);
    tick(1);
    chk("update_single", {63'b0, cfg_update}, 64'd0);
    issue(1'b0, 64'h20, '0, 8'h00);

    // Errored writes: read-only, misaligned, out of range
    issue(1'b1, 64'h18, '1, 8'hFF);
    issue(1'b1, 64'h0C, '1, 8'hFF);
    issue(1'b1, 64'h28, '1, 8'hFF);
    issue(1'b0, 64'h18, '0, 8'h00);
    issue(1'b0, 64'h0C, '0, 8'h00);
    issue(1'b0, 64'h08, '0, 8'h00);

    // Backpressure hold, then acceptance in the release cycle
    tick(1);
    rsp_ready = 1'b0;
    issue(1'b0, 64'h08, '0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("ready_low_stalled", {63'b0, req_ready}, 64'd0);
      chk("rsp_valid_stalled", {63'b0, rsp_valid}, 64'd1);
      tick(1);
    end
    rsp_ready = 1'b1;
    issue(1'b0, 64'h20, '0, 8'h00);
    chk("accept_on_release", 64'(last_wait), 64'd0);

    // Shadow write landing exactly in the commit cycle
    issue(1'b1, 64'h00, 64'h1111_2222_3333_4444, 8'hFF);
    core_idle = 1'b0;
    issue(1'b1, 64'h20, 64'h1, 8'h01);
    core_idle = 1'b1;
    issue(1'b1, 64'h00, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF);
    chk("commit_pre_write", cfg[63:0], 64'h1111_2222_3333_4444);
    issue(1'b0, 64'h20, '0, 8'h00);

    // Reset with a pending commit and a stalled response
    core_idle = 1'b0;
    issue(1'b1, 64'h20, 64'h1, 8'h01);
    tick(1);
    rsp_ready = 1'b0;
    issue(1'b0, 64'h00, '0, 8'h00);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rsp_dropped_by_reset", {63'b0, rsp_valid}, 64'd0);
    chk("cfg_cleared_by_reset", {63'b0, |cfg}, 64'd0);
    rsp_ready = 1'b1;
    core_idle = 1'b1;
    tick(1);
    chk("no_commit_after_reset", {63'b0, cfg_update}, 64'd0);
    issue(1'b0, 64'h20, '0, 8'h00);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      core_idle = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
      else a = 64'($urandom_range(0, 11) * 4);
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
    end

    rsp_ready = 1'b1;
    core_idle = 1'b1;
    tick(4);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
